// File: rtl/wb_stage.sv
// wb_stage: write-back and control-resolution stage behind the EX/WB register.
//   Selects register-file write data, resolves jump / N-Z branch redirects,
//   and squashes FLUSH_DEPTH younger instructions after each taken redirect.
//   All outputs are registered (one-cycle latency from the sampling edge).
// Ports:
//   clk, rst_n (async, active-low)
//   in_valid + EX/WB controls/flags/data/pc/rd  -> sampled each rising edge
//   rf_we/rf_waddr/rf_wdata                      -> register-file write port
//   redirect/redirect_pc                         -> one-cycle fetch redirect
//   flush                                        -> stage is squashing
// Optional: define WB_STATS_EN to add retired_count / squashed_count outputs.
module wb_stage #(
  parameter int FLUSH_DEPTH = 3,
  parameter int RF_ADDR_W   = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 reg_wrt,
  input  logic                 mem_to_reg,
  input  logic                 pc_to_reg,
  input  logic                 branching,
  input  logic                 branch_zero,
  input  logic                 jump,
  input  logic                 jump_mem,
  input  logic                 n,
  input  logic                 z,
  input  logic [31:0]          alu_result,
  input  logic [31:0]          data_mem_output,
  input  logic [31:0]          offset,
  input  logic [31:0]          pc,
  input  logic [RF_ADDR_W-1:0] rd,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 redirect,
  output logic [31:0]          redirect_pc,
`ifdef WB_STATS_EN
  output logic [31:0]          retired_count,
  output logic [31:0]          squashed_count,
`endif
  output logic                 flush
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;

  logic        w_accept;
  logic        w_squash;
  logic        w_taken;
  logic [31:0] w_link;
  logic [31:0] w_wdata;
  logic [31:0] w_br_tgt;
  logic [31:0] w_target;

  assign w_accept = in_valid && (r_state == RUN);
  assign w_squash = in_valid && (r_state == FLUSH);
  assign w_link   = pc + 32'd1;
  assign w_br_tgt = pc + offset;

  always_comb begin
    w_wdata = alu_result;
    if (pc_to_reg)       w_wdata = w_link;
    else if (mem_to_reg) w_wdata = data_mem_output;
  end

  // Taken resolution and target share one priority chain so the target
  // always belongs to the condition that fired.
  always_comb begin
    w_taken  = 1'b0;
    w_target = w_br_tgt;
    if (jump_mem) begin
      w_taken  = 1'b1;
      w_target = data_mem_output;
    end else if (jump) begin
      w_taken  = 1'b1;
      w_target = alu_result;
    end else if (branching && ((branch_zero && z) || (!branch_zero && n))) begin
      w_taken  = 1'b1;
      w_target = w_br_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      flush       <= 1'b0;
      r_state     <= RUN;
      r_cnt       <= '0;
    end else begin
      rf_we    <= w_accept && reg_wrt;
      redirect <= w_accept && w_taken;
      if (w_accept && reg_wrt) begin
        rf_waddr <= rd;
        rf_wdata <= w_wdata;
      end
      if (w_accept && w_taken) redirect_pc <= w_target;
      case (r_state)
        RUN: begin
          if (w_accept && w_taken) begin
            r_state <= FLUSH;
            r_cnt   <= 4'(FLUSH_DEPTH);
            flush   <= 1'b1;
          end
        end
        FLUSH: begin
          // cnt==1 at this edge means this is the last squashed input.
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= RUN;
            flush   <= 1'b0;
          end
        end
        default: begin
          r_state <= RUN;
          flush   <= 1'b0;
        end
      endcase
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count  <= '0;
      squashed_count <= '0;
    end else begin
      if (w_accept) retired_count  <= retired_count + 32'd1;
      if (w_squash) squashed_count <= squashed_count + 32'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_squash;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  logic        clk, rst_n;
  logic        in_valid, reg_wrt, mem_to_reg, pc_to_reg;
  logic        branching, branch_zero, jump, jump_mem, n, z;
  logic [31:0] alu_result, data_mem_output, offset, pc;
  logic [5:0]  rd;
  logic        rf_we, redirect, flush;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata, redirect_pc;

  wb_stage #(.FLUSH_DEPTH(3), .RF_ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .reg_wrt(reg_wrt),
    .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg), .branching(branching),
    .branch_zero(branch_zero), .jump(jump), .jump_mem(jump_mem), .n(n), .z(z),
    .alu_result(alu_result), .data_mem_output(data_mem_output), .offset(offset),
    .pc(pc), .rd(rd), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        red;
    logic [31:0] rpc;
    logic        fl;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [5:0]  h_waddr = '0;
  logic [31:0] h_wdata = '0;
  logic [31:0] h_rpc   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected output for the instruction being driven; fields that must hold
  // when their strobe is low take the last value the bench recorded.
  task automatic push(input string tag, input logic we, input logic [5:0] a,
                      input logic [31:0] d, input logic red, input logic [31:0] t,
                      input logic fl);
    exp_t e;
    if (we) begin h_waddr = a; h_wdata = d; end
    if (red) h_rpc = t;
    e.we = we; e.waddr = h_waddr; e.wdata = h_wdata;
    e.red = red; e.rpc = h_rpc; e.fl = fl; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".we"},    32'(rf_we),    32'(e.we));
      chk({e.tag, ".waddr"}, 32'(rf_waddr), 32'(e.waddr));
      chk({e.tag, ".wdata"}, rf_wdata,      e.wdata);
      chk({e.tag, ".red"},   32'(redirect), 32'(e.red));
      chk({e.tag, ".rpc"},   redirect_pc,   e.rpc);
      chk({e.tag, ".flush"}, 32'(flush),    32'(e.fl));
    end
  endtask

  task automatic idle();
    in_valid = 0; reg_wrt = 0; mem_to_reg = 0; pc_to_reg = 0;
    branching = 0; branch_zero = 0; jump = 0; jump_mem = 0; n = 0; z = 0;
    alu_result = 32'h0BAD_0001; data_mem_output = 32'h0BAD_0002;
    offset = 32'h0000_0004; pc = 32'h0000_0200; rd = 6'd1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".we"},    32'(rf_we),    0);
    chk({tag, ".waddr"}, 32'(rf_waddr), 0);
    chk({tag, ".wdata"}, rf_wdata,      0);
    chk({tag, ".red"},   32'(redirect), 0);
    chk({tag, ".rpc"},   redirect_pc,   0);
    chk({tag, ".flush"}, 32'(flush),    0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 0;
    #3 chk_zero("reset");
    #9 rst_n = 1;   // t=12, between edges

    // ALU write
    idle(); in_valid = 1; reg_wrt = 1; rd = 6'd5; alu_result = 32'h0000_1234;
    push("alu", 1, 6'd5, 32'h1234, 0, 0, 0); tick();

    // load write to rd=63
    idle(); in_valid = 1; reg_wrt = 1; mem_to_reg = 1; rd = 6'd63;
    data_mem_output = 32'hDEAD_BEEF; alu_result = 32'h5555_5555;
    push("load", 1, 6'd63, 32'hDEAD_BEEF, 0, 0, 0); tick();

    // zero branch taken: 0x100 + (-16) = 0xF0
    idle(); in_valid = 1; branching = 1; branch_zero = 1; z = 1;
    pc = 32'h100; offset = 32'hFFFF_FFF0;
    push("zbr", 0, 0, 0, 1, 32'hF0, 1); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); in_valid = 1; reg_wrt = 1; rd = 6'd7; alu_result = 32'(i + 16);
      push($sformatf("sq%0d", i), 0, 0, 0, 0, 0, (i < 2)); tick();
    end
    idle(); in_valid = 1; reg_wrt = 1; rd = 6'd7; alu_result = 32'h44;
    push("post", 1, 6'd7, 32'h44, 0, 0, 0); tick();

    // not taken (n=0 with branch_zero=0; z ignored)
    idle(); in_valid = 1; branching = 1; z = 1;
    push("ntk", 0, 0, 0, 0, 0, 0); tick();

    // controls ignored when in_valid=0
    idle(); jump = 1; reg_wrt = 1; alu_result = 32'h77;
    push("inval", 0, 0, 0, 0, 0, 0); tick();

    // negative branch taken: 0x10 + 0x20
    idle(); in_valid = 1; branching = 1; n = 1; pc = 32'h10; offset = 32'h20;
    push("nbr", 0, 0, 0, 1, 32'h30, 1); tick();
    idle(); push("nsq0", 0, 0, 0, 0, 0, 1); tick();
    idle(); push("nsq1", 0, 0, 0, 0, 0, 1); tick();
    idle(); push("nsq2", 0, 0, 0, 0, 0, 0); tick();

    // jump-and-link with pc wrap
    idle(); in_valid = 1; jump = 1; pc_to_reg = 1; reg_wrt = 1;
    pc = 32'hFFFF_FFFF; alu_result = 32'h40; rd = 6'd2;
    push("jal", 1, 6'd2, 32'h0, 1, 32'h40, 1); tick();
    idle(); in_valid = 1; jump_mem = 1; reg_wrt = 1; rd = 6'd3;
    data_mem_output = 32'h999;
    push("jmsq", 0, 0, 0, 0, 0, 1); tick();
    idle(); push("jsq1", 0, 0, 0, 0, 0, 1); tick();
    idle(); push("jsq2", 0, 0, 0, 0, 0, 0); tick();
    idle(); in_valid = 1; jump_mem = 1; data_mem_output = 32'h0000_0ABC;
    push("jmem", 0, 0, 0, 1, 32'hABC, 1); tick();
    idle(); push("jm1", 0, 0, 0, 0, 0, 1); tick();

    // reset in second flush cycle
    rst_n = 0;
    #1 chk_zero("midrst");
    h_waddr = '0; h_wdata = '0; h_rpc = '0;
    #2 rst_n = 1;
    idle(); in_valid = 1; reg_wrt = 1; rd = 6'd9; alu_result = 32'h55;
    push("afterrst", 1, 6'd9, 32'h55, 0, 0, 0); tick();
    idle(); push("quiet", 0, 0, 0, 0, 0, 0); tick();

    if (sb.size() != 0) begin
      checks++; errors++;
      $error("FAIL leftover: observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back and control-resolution stage that sits directly downstream of the EX/WB pipeline register. Each cycle it takes the registered EX/WB control bits and data, selects the register-file write data, resolves jumps and N/Z branches, and registers a one-cycle PC redirect. After every taken redirect it squashes a fixed number of younger in-flight instructions through a flush counter. All outputs are registered.

## Interface
Parameters:
- FLUSH_DEPTH, 3, number of younger instructions squashed after a redirect; legal range 1..15
- RF_ADDR_W, 6, register address width; matches EX/WB `rd`

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  the EX/WB register holds a real instruction this cycle
- reg_wrt, mem_to_reg, pc_to_reg  in  1 each  write-back controls
- branching, branch_zero, jump, jump_mem  in  1 each  control-flow controls
- n, z  in  1 each  ALU flags captured with the instruction
- alu_result  in  32  ALU output
- data_mem_output  in  32  data memory read value
- offset  in  32  branch offset, two's complement
- pc  in  32  PC of the instruction
- rd  in  RF_ADDR_W  destination register
- rf_we  out  1  register-file write enable
- rf_waddr  out  RF_ADDR_W  write address
- rf_wdata  out  32  write data
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  32  redirect target
- flush  out  1  the stage is squashing younger instructions

## Operation
- An instruction is accepted when in_valid=1 and the FSM is in RUN. When the FSM is in FLUSH, the instruction is squashed: it has no write and no redirect.
- Write data, in priority order:
  - pc_to_reg: pc+1
  - mem_to_reg: data_mem_output
  - otherwise: alu_result
- Arithmetic is modulo 2^32.
- Write: an accepted instruction with reg_wrt=1 drives rf_we=1, rf_waddr=rd and rf_wdata=the selected value. rd=0 is written like any other address.
- Taken condition and target, in priority order:
  - jump_mem: data_mem_output
  - jump: alu_result
  - branching & branch_zero & z: pc+offset
  - branching & ~branch_zero & n: pc+offset
- A taken instruction that also sets pc_to_reg writes its link value. The write and the redirect occur in the same cycle.
- FSM states:
  - RUN: an accepted taken instruction loads cnt=FLUSH_DEPTH and moves to FLUSH.
  - FLUSH: each cycle decrements cnt and squashes the input whether or not it is valid. Leaves for RUN when cnt reaches 1 at the edge.
- Controls are ignored when in_valid=0.

## Timing
- Latency: inputs are sampled at edge T; rf_*, redirect and redirect_pc are valid during cycle T+1.
- redirect is high for exactly one cycle per taken instruction.
- flush is high during cycles T+1 .. T+FLUSH_DEPTH. The inputs sampled at edges T+1 .. T+FLUSH_DEPTH are squashed. The input at edge T+FLUSH_DEPTH+1 is accepted.
- rf_we is 0 in every cycle without an accepted write.
- rf_waddr and rf_wdata hold their last values when rf_we=0.
- redirect_pc holds its last value when redirect=0.
- A taken instruction that arrives while in FLUSH is squashed and does not restart the counter.
- Reset values, applied asynchronously on rst_n=0: rf_we=0, rf_waddr=0, rf_wdata=0, redirect=0, redirect_pc=0, flush=0, state=RUN, cnt=0.
- Reset asserted mid-flush aborts the flush. The first edge after release accepts input normally.

## Configuration
- WB_STATS_EN defined: adds outputs retired_count and squashed_count, each 32 bits and reset to 0.
  - retired_count increments on each accepted instruction.
  - squashed_count increments on each valid instruction squashed in FLUSH.
  - Both wrap at 2^32.
- WB_STATS_EN not defined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- ALU write: rd=5, reg_wrt=1, alu_result=0x0000_1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, redirect=0.
- Load write: mem_to_reg=1, data_mem_output=0xDEAD_BEEF, rd=63 -> rf_wdata=0xDEAD_BEEF, rf_waddr=63.
- Zero branch, FLUSH_DEPTH=3: branching=1, branch_zero=1, z=1, pc=0x100, offset=0xFFFF_FFF0 -> redirect=1 with redirect_pc=0xF0 for one cycle.
  - flush is high for 3 cycles.
  - Three following valid reg_wrt instructions produce rf_we=0.
  - The fourth writes.
- Not-taken: branching=1, branch_zero=0, n=0 -> redirect=0, flush stays 0.
- Jump-and-link: jump=1, pc_to_reg=1, pc=0xFFFF_FFFF, alu_result=0x40, rd=2 -> rf_wdata=0x0, redirect_pc=0x40.
  - A jump_mem instruction arriving during the flush is ignored.
- Reset mid-flush: assert rst_n=0 in the second flush cycle -> all outputs are 0 immediately. After release, a valid write is accepted on the first edge.
